// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution issue stage

package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP,
        ST_FLUSH
    } conv_state_t;

    localparam logic [6:0]  CUSTOM_OPC_DEF = 7'b0001011;
    localparam logic [31:0] NOP_INSN_DEF   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] pc;
        logic        invalid;
        logic [4:0]  rd_idx;
        logic [4:0]  ra_idx;
        logic [4:0]  rb_idx;
        logic [31:0] ra_operand;
        logic [31:0] rb_operand;
    } issue_fields_t;

    function automatic logic is_custom(input logic [31:0] insn, input logic [6:0] opc);
        return insn[6:0] == opc;
    endfunction

endpackage

// File: rtl/conv_timeout_ctr.sv
// rtl/conv_timeout_ctr.sv - saturating cycle counter used to abort a stuck conv operation

module conv_timeout_ctr (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count;

    // Clear wins over enable so the first cycle after entry always reads zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/conv_issue.sv
// rtl/conv_issue.sv - issues custom instructions to the convolution unit and returns its writeback

module conv_issue
    import conv_pkg::*;
#(
    parameter logic [6:0]  CUSTOM_OPC     = CUSTOM_OPC_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] NOP_INSN       = NOP_INSN_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [31:0] issue_opcode_i,
    input  logic [31:0] issue_pc_i,
    input  logic        issue_invalid_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [4:0]  issue_ra_idx_i,
    input  logic [4:0]  issue_rb_idx_i,
    input  logic [31:0] issue_ra_operand_i,
    input  logic [31:0] issue_rb_operand_i,
    output logic        issue_accept_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic [31:0] conv_opcode_o,
    output logic [31:0] conv_pc_o,
    output logic        conv_invalid_o,
    output logic [4:0]  conv_rd_idx_o,
    output logic [4:0]  conv_ra_idx_o,
    output logic [4:0]  conv_rb_idx_o,
    output logic [31:0] conv_ra_operand_o,
    output logic [31:0] conv_rb_operand_o,
    input  logic        conv_busy_i,
    input  logic        conv_valid_i,
    input  logic [31:0] conv_writeback_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    input  logic        wb_ready_i,
    output logic        timeout_o
);

    conv_state_t   state, next_state;
    issue_fields_t lat;
    logic [31:0]   wb_value_q;
    logic          accept_ok;
    logic          capture;
    logic          expired;
    logic          in_count_state;
    logic          ctr_clear;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign accept_ok = rst_i && (state == ST_IDLE) && issue_valid_i
                     && is_custom(issue_opcode_i, CUSTOM_OPC) && !conv_busy_i && !flush_i;
    assign capture   = conv_valid_i && !flush_i && ((state == ST_LAUNCH) || (state == ST_WAIT));

    assign in_count_state = (state == ST_WAIT) || (state == ST_FLUSH);
    assign ctr_clear      = ((next_state == ST_WAIT) || (next_state == ST_FLUSH)) && (next_state != state);

    conv_timeout_ctr u_timeout_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (ctr_clear),
        .enable  (in_count_state),
        .limit   (32'(TIMEOUT_CYCLES)),
        .expired (expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat        <= '0;
            wb_value_q <= '0;
        end else begin
            if (accept_ok) begin
                lat <= '{opcode: issue_opcode_i, pc: issue_pc_i, invalid: issue_invalid_i,
                         rd_idx: issue_rd_idx_i, ra_idx: issue_ra_idx_i, rb_idx: issue_rb_idx_i,
                         ra_operand: issue_ra_operand_i, rb_operand: issue_rb_operand_i};
            end
            if (capture) begin
                wb_value_q <= conv_writeback_i;
            end
        end
    end

    // Flush outranks a result arriving in the same cycle; a result outranks a timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept_ok) next_state = ST_LAUNCH;
            end
            ST_LAUNCH, ST_WAIT: begin
                if (flush_i) begin
                    next_state = ST_FLUSH;
                end else if (conv_valid_i) begin
                    next_state = (lat.rd_idx == 5'd0) ? ST_IDLE : ST_RESP;
                end else if (state == ST_LAUNCH) begin
                    next_state = ST_WAIT;
                end else if (expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (flush_i || wb_ready_i) next_state = ST_IDLE;
            end
            ST_FLUSH: begin
                if (conv_valid_i || !conv_busy_i || expired) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_accept_o    = accept_ok;
        stall_o           = (state != ST_IDLE);
        wb_valid_o        = (state == ST_RESP) && !flush_i;
        wb_rd_idx_o       = lat.rd_idx;
        wb_value_o        = wb_value_q;
        timeout_o         = ((state == ST_WAIT) && !flush_i && !conv_valid_i && expired)
                         || ((state == ST_FLUSH) && !conv_valid_i && conv_busy_i && expired);
        conv_opcode_o     = (state == ST_LAUNCH) ? lat.opcode : NOP_INSN;
        conv_invalid_o    = (state == ST_LAUNCH) && lat.invalid;
        conv_pc_o         = lat.pc;
        conv_rd_idx_o     = lat.rd_idx;
        conv_ra_idx_o     = lat.ra_idx;
        conv_rb_idx_o     = lat.rb_idx;
        conv_ra_operand_o = lat.ra_operand;
        conv_rb_operand_o = lat.rb_operand;
    end

endmodule

// File: doc/conv_issue.md
CONV_ISSUE -- requirements
Module: conv_issue

Interface
REQ-001 SHALL have parameter CUSTOM_OPC, default 7'b0001011, meaning the opcode[6:0] value routed to the convolution unit.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of WAIT/FLUSH cycles before abort.
REQ-003 SHALL have parameter NOP_INSN, default 32'h0000_0013, meaning the opcode driven to the unit when not launching.
REQ-004 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 issue_valid_i  in  1  the decode stage presents an instruction.
REQ-007 issue_opcode_i / issue_pc_i  in  32/32  instruction word and PC.
REQ-008 issue_invalid_i  in  1  the decoder flags the instruction as illegal.
REQ-009 issue_rd_idx_i / issue_ra_idx_i / issue_rb_idx_i  in  5 each  register indices.
REQ-010 issue_ra_operand_i / issue_rb_operand_i  in  32 each  source operand values.
REQ-011 issue_accept_o  out  1  the instruction is taken this cycle.
REQ-012 stall_o  out  1  holds the pipeline while a conv operation is in flight.
REQ-013 flush_i  in  1  pipeline flush; in-flight result is discarded.
REQ-014 conv_opcode_o / conv_pc_o / conv_invalid_o / conv_rd_idx_o / conv_ra_idx_o / conv_rb_idx_o / conv_ra_operand_o / conv_rb_operand_o  out  32/32/1/5/5/5/32/32  drive the unit's opcode_* inputs.
REQ-015 conv_busy_i / conv_valid_i / conv_writeback_i  in  1/1/32  from the unit's busy_o/valid_o/writeback_o.
REQ-016 wb_valid_o / wb_rd_idx_o / wb_value_o  out  1/5/32  register-file writeback request.
REQ-017 wb_ready_i  in  1  writeback port accepts the request.
REQ-018 timeout_o  out  1  one-cycle pulse on abort after timeout.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP, FLUSH.
REQ-020 IDLE: issue_accept_o=1 iff issue_valid_i && issue_opcode_i[6:0]==CUSTOM_OPC && !conv_busy_i && !flush_i; on accept, latch all issue_* fields and go to LAUNCH.
REQ-021 LAUNCH (exactly 1 cycle): conv_* outputs SHALL present the latched fields; in every other state conv_opcode_o=NOP_INSN, conv_invalid_o=0, and the other conv_* outputs hold their latched values.
REQ-022 LAUNCH goes to WAIT; if conv_valid_i=1 in LAUNCH, capture the result and go directly to RESP.
REQ-023 WAIT: on conv_valid_i, capture conv_writeback_i into wb_value_o; go to RESP, or to IDLE if the latched rd_idx==0 (no x0 write).
REQ-024 RESP: wb_valid_o=1 with stable wb_rd_idx_o/wb_value_o until wb_ready_i; go to IDLE in the cycle wb_ready_i is 1.
REQ-025 stall_o SHALL be 1 in every state except IDLE.
REQ-026 Minimum latency: accept at cycle N, launch at N+1, wb_valid_o at N+2.
REQ-027 flush_i in LAUNCH or WAIT goes to FLUSH; flush_i in RESP drops wb_valid_o and goes to IDLE; flush_i in IDLE blocks the accept.
REQ-028 FLUSH: no writeback; return to IDLE on conv_valid_i, or on conv_busy_i=0 after at least one cycle in FLUSH.
REQ-029 A 32-bit saturating cycle counter SHALL clear on entry to WAIT/FLUSH and count each cycle in WAIT/FLUSH.
REQ-030 When the counter reaches TIMEOUT_CYCLES: pulse timeout_o, go to IDLE, no writeback.
REQ-031 conv_valid_i outside LAUNCH/WAIT/FLUSH SHALL be ignored.

Reset
REQ-032 Asserting rst_i low from any state SHALL immediately force IDLE and drive outputs to: issue_accept_o=0, stall_o=0, wb_valid_o=0, wb_rd_idx_o=0, wb_value_o=0, timeout_o=0, conv_opcode_o=NOP_INSN, conv_invalid_o=0, all other conv_* =0; counter=0.
REQ-033 The first accept after reset release SHALL be possible on the first rising edge with rst_i high.

Structure
REQ-034 Package conv_pkg SHALL hold the FSM state enum, CUSTOM_OPC default, NOP_INSN and the issue-field struct (opcode, pc, invalid, rd/ra/rb idx, ra/rb operands).
REQ-035 One sub-module, conv_timeout_ctr (clear, enable, limit, expired), SHALL implement the timeout counter.

Verification
REQ-036 Opcode 0x0020_810B with rd=5, unit valid 3 cycles after launch, writeback 0xDEAD_BEEF, wb_ready_i=1 -> wb_valid_o for 1 cycle with rd=5 and value 0xDEAD_BEEF; stall_o high for 5 cycles.
REQ-037 Same operation with rd=0 -> no wb_valid_o; IDLE on the cycle after conv_valid_i.
REQ-038 wb_ready_i held low for 4 cycles in RESP -> wb_valid_o and its data stable for 5 cycles; next issue accepted only after that.
REQ-039 flush_i in the 2nd WAIT cycle, unit valid 2 cycles later -> no writeback; IDLE; stall_o=0 the following cycle.
REQ-040 TIMEOUT_CYCLES=8, unit never valid -> timeout_o pulse 8 cycles after entering WAIT; then IDLE.
REQ-041 conv_busy_i=1 in IDLE with a valid custom issue -> issue_accept_o=0 until busy drops; opcode 0x0000_0033 (non-custom) is never accepted.
